// File: rtl/uart_rx_fifo_wr.sv
// 8N1 UART receiver with 16x oversampling.
// Each good byte is pushed into the RX FIFO with a one-clk write strobe.
module uart_rx_fifo_wr #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    input  logic                  rx_fifo_full,
    input  logic                  err_clr,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] MID       = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST      = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                  state;
    logic                    sync1;
    logic                    rxd_s;
    logic                    rxd_prev;
    logic [TW-1:0]           tick_cnt;
    logic [SW-1:0]           sample_cnt;
    logic [BW-1:0]           bit_idx;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    tick;
    logic                    start_edge;

    assign tick       = (tick_cnt == TICK_LAST);
    assign start_edge = (state == IDLE) && rxd_prev && !rxd_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sync1       <= 1'b1;
            rxd_s       <= 1'b1;
            rxd_prev    <= 1'b1;
            tick_cnt    <= '0;
            sample_cnt  <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync1    <= rxd;
            rxd_s    <= sync1;
            rxd_prev <= rxd_s;
            wr_en    <= 1'b0;

            // Restart on the start edge keeps ticks phase-aligned to the frame
            if (start_edge || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);

            if (err_clr) begin
                frame_err   <= 1'b0;
                overrun_err <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        state      <= START;
                        sample_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt == MID) begin
                            if (rxd_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state      <= DATA;
                                sample_cnt <= '0;
                                bit_idx    <= '0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sample_cnt == LAST) begin
                            sample_cnt <= '0;
                            shift <= {rxd_s, shift[DATA_WIDTH-1:1]};
                            if (bit_idx == LAST_BIT) begin
                                state   <= STOP;
                                bit_idx <= '0;
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (sample_cnt == LAST) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            sample_cnt <= '0;
                            // Error sets come after err_clr so they win
                            if (rxd_s && !rx_fifo_full) begin
                                wr_data <= shift;
                                wr_en   <= 1'b1;
                            end else if (rxd_s) begin
                                overrun_err <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Scoreboard bench for uart_rx_fifo_wr.
// Uses a scaled clock rate so one bit is 64 clk (4 clk per tick).
module tb_uart_rx_fifo_wr;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rx_fifo_full;
    logic       err_clr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] exp_q[$];
    int         exp_t[$];
    bit         m_frm = 0;
    bit         m_ovr = 0;
    bit         prev_wr = 0;

    uart_rx_fifo_wr #(
        .CLK_FREQ  (614400),
        .BAUD      (9600),
        .OVERSAMPLE(16),
        .DATA_WIDTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .rx_fifo_full(rx_fifo_full),
        .err_clr     (err_clr),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act,
                         input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tickn(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every write must match the oldest expected byte
    always @(negedge clk) begin
        int lat;
        logic [7:0] d;
        if (!reset) begin
            if (wr_en) begin
                check("wr_en_gap", int'(prev_wr), 0);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write actual=%0h required=none",
                             wr_data);
                end else begin
                    d   = exp_q.pop_front();
                    lat = cyc - exp_t.pop_front();
                    check("wr_data", int'(wr_data), int'(d));
                    compared++;
                    if (lat < 600 || lat > 620) begin
                        mismatched++;
                        $display("FAIL latency actual=%0d required=600..620",
                                 lat);
                    end
                end
            end
            prev_wr = wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    // Model: a frame is written, overruns, or is a framing error
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        if (stop_ok && !rx_fifo_full) begin
            exp_q.push_back(d);
            exp_t.push_back(cyc);
        end else if (stop_ok) begin
            m_ovr = 1'b1;
        end else begin
            m_frm = 1'b1;
        end
        rxd = 1'b0;
        tickn(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tickn(BIT);
        end
        rxd = stop_ok;
        tickn(BIT);
        rxd = 1'b1;
        if (!stop_ok) tickn(16);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_err"}, int'(frame_err), int'(m_frm));
        check({tag, "_overrun_err"}, int'(overrun_err), int'(m_ovr));
    endtask

    task automatic check_reset_outs();
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun_err", int'(overrun_err), 0);
        check("rst_busy", int'(busy), 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tickn(1);
        err_clr = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        tickn(2);
    endtask

    initial begin
        logic [7:0] d;
        bit ok;
        reset = 1'b1;
        rxd = 1'b1;
        rx_fifo_full = 1'b0;
        err_clr = 1'b0;
        tickn(3);
        check_reset_outs();
        reset = 1'b0;

        tickn(2000);
        check_state("idle");

        send_frame(8'hA5, 1'b1);
        tickn(20);
        check_state("single");

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        tickn(20);
        check_state("b2b");

        rxd = 1'b0;
        tickn(16);
        rxd = 1'b1;
        tickn(200);
        check_state("glitch");

        send_frame(8'h55, 1'b0);
        tickn(20);
        check_state("framing");
        pulse_clr();
        check_state("clr");

        rxd = 1'b0;
        tickn(2000);
        rxd = 1'b1;
        m_frm = 1'b1;
        tickn(50);
        check_state("break");
        pulse_clr();

        rx_fifo_full = 1'b1;
        send_frame(8'h81, 1'b1);
        rx_fifo_full = 1'b0;
        tickn(20);
        check_state("overrun");
        send_frame(8'h7E, 1'b1);
        tickn(20);
        check_state("after_ovr");

        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 4) == 0) pulse_clr();
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            rx_fifo_full = ($urandom_range(0, 3) == 0);
            send_frame(d, ok);
            rx_fifo_full = 1'b0;
            tickn($urandom_range(0, 40));
            check_state("rand");
        end

        if (m_ovr == 1'b0) begin
            rx_fifo_full = 1'b1;
            send_frame(8'h5A, 1'b1);
            rx_fifo_full = 1'b0;
            tickn(10);
        end

        d = 8'hC3;
        rxd = 1'b0;
        tickn(BIT);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            tickn(BIT);
        end
        rxd = d[4];
        tickn(BIT / 2);
        reset = 1'b1;
        tickn(1);
        for (int i = 0; i < 3; i++) begin
            check_reset_outs();
            tickn(1);
        end
        rxd = 1'b1;
        reset = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        tickn(100);
        send_frame(8'h12, 1'b1);
        tickn(50);
        check_state("post_rst");

        check("pending_writes", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
